// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with one-shot and auto-reload modes.
// Three software-visible registers sit in a 16-byte window at BASE:
//   +0 CTRL   {IM, Mode[1:0], Enable}
//   +4 PRESET reload value, sampled only when the FSM enters LOAD
//   +8 COUNT  live counter value, read-only
//   +C reserved, reads 0
// IRQ is a level output, the interrupt flag gated by CTRL.IM.
module timer_counter #(
    parameter logic [31:0] BASE = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic [3:0]  ByteEn,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;
    localparam logic [1:0] MODE_RELOAD = 2'b01;

    state_t      r_state;
    logic [3:0]  r_ctrl;
    logic [31:0] r_preset;
    logic [31:0] r_count;
    logic        r_irq_flag;

    logic        w_sel;
    logic        w_we;
    logic        w_wr_ctrl;
    logic        w_wr_preset;
    logic [1:0]  w_off;
    logic        w_enable;
    logic [1:0]  w_mode;
    logic        w_im;
    logic        w_count_gt1;
    logic        w_unused_addr;

    // The two low address bits are byte lanes; word registers ignore them.
    assign w_unused_addr = ^Addr[1:0];

    // Window decode and write qualification: only full-word stores count.
    assign w_off       = Addr[3:2];
    assign w_sel       = (Addr[31:4] == BASE[31:4]);
    assign w_we        = w_sel && (ByteEn == 4'b1111);
    assign w_wr_ctrl   = w_we && (w_off == OFF_CTRL);
    assign w_wr_preset = w_we && (w_off == OFF_PRESET);

    assign w_enable    = r_ctrl[0];
    assign w_mode      = r_ctrl[2:1];
    assign w_im        = r_ctrl[3];
    assign w_count_gt1 = (r_count > 32'd1);

    // Holds the reload value; only software changes it, the FSM just samples it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_preset <= 32'd0;
        end else if (w_wr_preset) begin
            r_preset <= Din;
        end
    end

    // Counter FSM plus CTRL and the interrupt flag; a software CTRL write
    // is applied last so it overrides anything the FSM did that cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_ctrl     <= 4'd0;
            r_count    <= 32'd0;
            r_irq_flag <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_enable) begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_count <= r_preset;
                    r_state <= S_CNT;
                end
                S_CNT: begin
                    if (!w_enable) begin
                        r_state <= S_IDLE;
                    end else if (w_count_gt1) begin
                        r_count <= r_count - 32'd1;
                    end else begin
                        // Covers COUNT of 1 and 0, so a zero preset
                        // expires at once and the counter cannot wrap.
                        r_count    <= 32'd0;
                        r_irq_flag <= 1'b1;
                        r_state    <= S_INT;
                    end
                end
                S_INT: begin
                    if (w_mode == MODE_RELOAD) begin
                        r_irq_flag <= 1'b0;
                    end else begin
                        // One-shot: stop and leave the flag up for software.
                        r_ctrl[0] <= 1'b0;
                    end
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            if (w_wr_ctrl) begin
                r_ctrl     <= Din[3:0];
                r_irq_flag <= 1'b0;
            end
        end
    end

    // Read mux, selected by word offset regardless of byte enables.
    always_comb begin
        Dout = 32'd0;
        case (w_off)
            OFF_CTRL:   Dout = {28'd0, r_ctrl};
            OFF_PRESET: Dout = r_preset;
            OFF_COUNT:  Dout = r_count;
            default:    Dout = 32'd0;
        endcase
    end

    assign IRQ = w_im & r_irq_flag;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: a register-access vector table followed
// by hand-written multi-cycle timing sequences.
module tb_timer_counter;

    localparam logic [31:0] BASE = 32'h0000_7F00;

    logic        clk;
    logic        reset;
    logic [31:0] Addr;
    logic [3:0]  ByteEn;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    int checks;
    int failures;

    timer_counter #(.BASE(BASE)) dut (
        .clk    (clk),
        .reset  (reset),
        .Addr   (Addr),
        .ByteEn (ByteEn),
        .Din    (Din),
        .Dout   (Dout),
        .IRQ    (IRQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] din;
        logic [1:0]  rd;
        logic [31:0] exp_dout;
        logic        exp_irq;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end else begin
            $display("ok   %s value=%h", name, act);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        Addr   = a;
        ByteEn = be;
        Din    = d;
        cyc();
        ByteEn = 4'd0;
    endtask

    task automatic rd(input logic [1:0] off, output logic [31:0] d);
        Addr = BASE + {28'd0, off, 2'b00};
        #1;
        d = Dout;
    endtask

    task automatic do_reset();
        reset  = 1'b0;
        ByteEn = 4'd0;
        cyc();
        reset = 1'b1;
    endtask

    logic [31:0] rdata;
    logic [31:0] exp_cnt [10];
    logic        exp_irq [10];
    bit          found;

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        Addr     = BASE;
        ByteEn   = 4'd0;
        Din      = 32'd0;
        cyc();
        cyc();
        reset = 1'b1;

        // Register access table; Enable stays 0 so the FSM never runs here.
        vecs[0]  = '{32'h0000_7F00, 4'h0, 32'h0,         2'd0, 32'h0,         1'b0};
        vecs[1]  = '{32'h0000_7F00, 4'h0, 32'h0,         2'd1, 32'h0,         1'b0};
        vecs[2]  = '{32'h0000_7F00, 4'h0, 32'h0,         2'd2, 32'h0,         1'b0};
        vecs[3]  = '{32'h0000_7F00, 4'h0, 32'h0,         2'd3, 32'h0,         1'b0};
        vecs[4]  = '{32'h0000_7F04, 4'hF, 32'h1234_5678, 2'd1, 32'h1234_5678, 1'b0};
        vecs[5]  = '{32'h0000_7F04, 4'h3, 32'hFFFF_FFFF, 2'd1, 32'h1234_5678, 1'b0};
        vecs[6]  = '{32'h0000_7F04, 4'hE, 32'h0,         2'd1, 32'h1234_5678, 1'b0};
        vecs[7]  = '{32'h0000_7F08, 4'hF, 32'hFFFF_FFFF, 2'd2, 32'h0,         1'b0};
        vecs[8]  = '{32'h0000_7F0C, 4'hF, 32'hFFFF_FFFF, 2'd3, 32'h0,         1'b0};
        vecs[9]  = '{32'h0000_7F20, 4'hF, 32'hFFFF_FFF6, 2'd0, 32'h0,         1'b0};
        vecs[10] = '{32'h0000_7F24, 4'hF, 32'h0,         2'd1, 32'h1234_5678, 1'b0};
        vecs[11] = '{32'h0000_7F00, 4'hF, 32'hFFFF_FFF6, 2'd0, 32'h6,         1'b0};
        vecs[12] = '{32'h0000_7F00, 4'h7, 32'h0,         2'd0, 32'h6,         1'b0};
        vecs[13] = '{32'h0001_7F00, 4'hF, 32'h0,         2'd0, 32'h6,         1'b0};
        vecs[14] = '{32'h0000_7F00, 4'hF, 32'h0,         2'd0, 32'h0,         1'b0};

        for (int i = 0; i < 15; i++) begin
            wr(vecs[i].addr, vecs[i].be, vecs[i].din);
            rd(vecs[i].rd, rdata);
            chk($sformatf("vec%0d_dout", i), rdata, vecs[i].exp_dout);
            chk($sformatf("vec%0d_irq", i), {31'd0, IRQ}, {31'd0, vecs[i].exp_irq});
        end

        // Mode 0 one-shot, with a PRESET write mid-count.
        do_reset();
        wr(BASE + 32'h4, 4'hF, 32'd3);
        wr(BASE + 32'h0, 4'hF, 32'h9);
        Addr = BASE + 32'h8;
        cyc();                                  // LOAD
        cyc(); chk("m0_count3", Dout, 32'd3);
        chk("m0_irq_lo", {31'd0, IRQ}, 32'd0);
        cyc(); chk("m0_count2", Dout, 32'd2);
        wr(BASE + 32'h4, 4'hF, 32'd7);
        Addr = BASE + 32'h8;
        #1; chk("m0_count1_preset_nochg", Dout, 32'd1);
        cyc(); chk("m0_count0", Dout, 32'd0);
        chk("m0_irq_rise", {31'd0, IRQ}, 32'd1);
        cyc();
        rd(2'd0, rdata); chk("m0_ctrl_after", rdata, 32'h8);
        cyc(); cyc(); cyc();
        chk("m0_irq_hold", {31'd0, IRQ}, 32'd1);
        rd(2'd2, rdata); chk("m0_count_stays0", rdata, 32'd0);
        rd(2'd1, rdata); chk("m0_preset_new", rdata, 32'd7);

        // Mode 1 auto-reload: two full periods.
        do_reset();
        exp_cnt = '{32'd0, 32'd2, 32'd1, 32'd0, 32'd0, 32'd0, 32'd2, 32'd1, 32'd0, 32'd0};
        exp_irq = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        wr(BASE + 32'h4, 4'hF, 32'd2);
        wr(BASE + 32'h0, 4'hF, 32'hB);
        Addr = BASE + 32'h8;
        for (int k = 0; k < 10; k++) begin
            cyc();
            chk($sformatf("m1_count_c%0d", k), Dout, exp_cnt[k]);
            chk($sformatf("m1_irq_c%0d", k), {31'd0, IRQ}, {31'd0, exp_irq[k]});
        end

        // Masked expiry, then a CTRL write must clear the pending flag.
        do_reset();
        wr(BASE + 32'h4, 4'hF, 32'd1);
        wr(BASE + 32'h0, 4'hF, 32'h1);
        for (int k = 0; k < 6; k++) cyc();
        chk("mask_irq_lo", {31'd0, IRQ}, 32'd0);
        rd(2'd0, rdata); chk("mask_ctrl_en_clr", rdata, 32'h0);
        wr(BASE + 32'h0, 4'hF, 32'h8);
        cyc();
        chk("mask_flag_cleared", {31'd0, IRQ}, 32'd0);

        // PRESET = 0 expires on the first CNT cycle.
        do_reset();
        wr(BASE + 32'h0, 4'hF, 32'h9);
        Addr = BASE + 32'h8;
        cyc();                                  // LOAD
        cyc(); chk("p0_irq_lo", {31'd0, IRQ}, 32'd0);
        cyc(); chk("p0_irq_hi", {31'd0, IRQ}, 32'd1);
        chk("p0_count0", Dout, 32'd0);

        // Reset mid-count at COUNT = 6, with a concurrent CTRL write.
        do_reset();
        wr(BASE + 32'h4, 4'hF, 32'd10);
        wr(BASE + 32'h0, 4'hF, 32'h9);
        Addr  = BASE + 32'h8;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            cyc();
            if (Dout == 32'd6) found = 1'b1;
        end
        chk("rst_wait_count6", {31'd0, found}, 32'd1);
        reset = 1'b0;
        wr(BASE + 32'h0, 4'hF, 32'hF);
        reset = 1'b1;
        chk("rst_irq", {31'd0, IRQ}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            rd(k[1:0], rdata);
            chk($sformatf("rst_off%0d", k), rdata, 32'd0);
        end
        cyc();
        rd(2'd2, rdata); chk("rst_count_idle", rdata, 32'd0);

        // CPU CTRL write in the INT cycle beats the FSM's Enable clear.
        do_reset();
        wr(BASE + 32'h4, 4'hF, 32'd1);
        wr(BASE + 32'h0, 4'hF, 32'h9);
        cyc();                                  // LOAD
        cyc();                                  // CNT, count 1
        cyc();                                  // now in INT
        chk("sim_irq_hi", {31'd0, IRQ}, 32'd1);
        wr(BASE + 32'h0, 4'hF, 32'h5);
        rd(2'd0, rdata); chk("sim_ctrl", rdata, 32'h5);
        chk("sim_irq_lo", {31'd0, IRQ}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/timer_counter.md
TIMER_COUNTER -- requirements
Module: timer_counter

Interface
REQ-001 Parameter BASE, default 32'h0000_7F00, word-aligned base address of the 16-byte register window.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-low; sampled only on rising clk.
REQ-004 Addr  input  32  byte address from the MEM-stage ALU result; Addr[3:2] selects the register.
REQ-005 ByteEn  input  4  byte enables produced by the upstream store byte-enable stage.
REQ-006 Din  input  32  store data aligned by the upstream stage.
REQ-007 Dout  output  32  read data for the addressed register, combinational.
REQ-008 IRQ  output  1  interrupt request toward the CP0 HWInt input, level.

Function
REQ-009 The block SHALL treat Addr as selecting it when Addr[31:4] == BASE[31:4].
REQ-010 A write SHALL occur only when the block is selected and ByteEn == 4'b1111; all partial enables SHALL be ignored.
REQ-011 Registers: offset 0 CTRL (bit3 IM, bits2:1 Mode, bit0 Enable, bits31:4 read 0), offset 4 PRESET, offset 8 COUNT (read-only), offset C reads 0.
REQ-012 Writes to offset 8 or C SHALL have no effect.
REQ-013 Dout SHALL return {28'b0, CTRL[3:0]}, PRESET, COUNT or 0 per Addr[3:2], independent of ByteEn.
REQ-014 FSM states: IDLE, LOAD, CNT, INT.
REQ-015 IDLE: if Enable = 1, next state is LOAD; otherwise stay.
REQ-016 LOAD: COUNT <= PRESET; next state is CNT.
REQ-017 CNT, Enable = 0: next state is IDLE; COUNT holds.
REQ-018 CNT, Enable = 1, COUNT > 1: COUNT <= COUNT - 1; stay in CNT.
REQ-019 CNT, Enable = 1, COUNT <= 1: COUNT <= 0, irq_flag <= 1, next state is INT.
REQ-020 INT, Mode == 2'b01: irq_flag <= 0; next state is IDLE, which reloads if Enable is still set.
REQ-021 INT, any other Mode: Enable <= 0, irq_flag holds; next state is IDLE.
REQ-022 IRQ SHALL equal CTRL.IM & irq_flag.
REQ-023 Any CTRL write SHALL clear irq_flag.
REQ-024 A CPU CTRL write in the same cycle as the FSM clearing Enable SHALL win; the written value is stored.
REQ-025 A PRESET write SHALL take effect at the next LOAD; it SHALL NOT alter an in-progress COUNT.
REQ-026 PRESET = 0 SHALL behave as PRESET = 1: the count reaches INT on the first CNT cycle.
REQ-027 COUNT SHALL never wrap below 0.
REQ-028 Mode values 2'b10 and 2'b11 SHALL behave as mode 0.

Reset
REQ-029 When reset = 0 at a rising edge, CTRL, PRESET, COUNT and irq_flag SHALL become 0 and the state SHALL become IDLE.
REQ-030 After reset, Dout = 0 for every offset and IRQ = 0.
REQ-031 Reset asserted mid-count SHALL abort immediately, with no IRQ pulse and no write taking effect in that cycle.

Verification
REQ-032 Mode 0 one-shot:
- Stimulus: write PRESET = 3, then CTRL = 4'b1001.
- Required: COUNT reads 3, 2, 1, 0 on successive cycles after LOAD.
- Required: IRQ rises on entry to INT and stays 1.
- Required: CTRL reads 4'b1000 afterwards.
REQ-033 Mode 1 auto-reload:
- Stimulus: PRESET = 2, CTRL = 4'b1011.
- Required: IRQ is high for exactly one cycle per period.
- Required: COUNT sequence 2, 1, 0, then reload to 2, repeating every 5 cycles.
REQ-034 Masked interrupt and flag clear:
- Stimulus: CTRL = 4'b0001, PRESET = 1.
- Required: IRQ stays 0 after expiry.
- Stimulus: write CTRL = 4'b1000.
- Required: IRQ stays 0 because irq_flag was cleared.
REQ-035 Write filtering:
- Stimulus: ByteEn = 4'b0011 to offset 4 with Din = 32'hFFFF_FFFF.
- Required: PRESET unchanged.
- Stimulus: write to offset 8.
- Required: COUNT unchanged.
- Stimulus: access at Addr 32'h7F20.
- Required: no register affected.
REQ-036 Reset mid-count:
- Stimulus: PRESET = 10, Enable set; drive reset = 0 at COUNT = 6.
- Required: all registers read 0 and IRQ = 0 on the next cycle.
REQ-037 Simultaneous events:
- Stimulus: CTRL write of 4'b0101 in the INT cycle of a mode-0 count.
- Required: CTRL reads 4'b0101 and irq_flag = 0.
